// File: rtl/kp_pkg.sv
// kp_pkg: keypad key codes and the row/column to key-code map
package kp_pkg;
  localparam logic [4:0] KEY_NONE = 5'd31;
  localparam logic [4:0] KEY_PWRB = 5'd10;
  localparam logic [4:0] KEY_STB = 5'd13;
  localparam logic [4:0] KEY_NO = 5'd14;
  localparam logic [4:0] KEY_YES = 5'd15;
  localparam logic [79:0] KEY_MAP = {
    5'd13, 5'd15, 5'd0, 5'd14,
    5'd12, 5'd9, 5'd8, 5'd7,
    5'd11, 5'd6, 5'd5, 5'd4,
    5'd10, 5'd3, 5'd2, 5'd1
  };
  function automatic logic [4:0] kp_map(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col} * 7'd5 +: 5];
  endfunction
endpackage

// File: rtl/kp_debounce.sv
// kp_debounce: commits a scan code after DEBOUNCE_SCANS identical scans; in scan_valid, scan_code; out keypad_pressed, key, key_strobe
module kp_debounce
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [4:0] scan_code,
  output logic       keypad_pressed,
  output logic [4:0] key,
  output logic       key_strobe
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_SCANS);
  logic [4:0] cand;
  logic [CW-1:0] cnt, cnt_nx;
  logic same, commit, accept;
  always_comb begin
    same = scan_code == cand;
    cnt_nx = !same ? CW'(1) : (cnt == FULL ? FULL : cnt + 1'b1);
    commit = scan_valid && cnt_nx == FULL && !(same && cnt == FULL);
    accept = commit && scan_code != KEY_NONE && (!keypad_pressed || scan_code != key);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= KEY_NONE;
      cnt <= '0;
      keypad_pressed <= 1'b0;
      key <= KEY_NONE;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= accept;
      if (scan_valid) begin
        cand <= scan_code;
        cnt <= cnt_nx;
      end
      if (accept) begin
        key <= scan_code;
        keypad_pressed <= 1'b1;
      end else if (commit && scan_code == KEY_NONE) begin
        keypad_pressed <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scan with column sync and single-key decode; in col_n, out row_n, keypad_pressed, key, key_strobe
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = 27000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       keypad_pressed,
  output logic [4:0] key,
  output logic       key_strobe
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);
  logic [3:0] sync1, col_s;
  logic [TW-1:0] tick;
  logic [1:0] row, hits, hits_nx;
  logic [4:0] code, code_nx, scan_code;
  logic slot_end, scan_valid;
  always_comb begin
    slot_end = tick == LAST;
    hits_nx = hits;
    code_nx = code;
    for (int c = 0; c < 4; c++) begin
      if (!col_s[c]) begin
        hits_nx = hits_nx == 2'd2 ? 2'd2 : hits_nx + 1'b1;
        code_nx = kp_map(row, 2'(c));
      end
    end
    scan_valid = slot_end && row == 2'd3;
    scan_code = hits_nx == 2'd1 ? code_nx : KEY_NONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      col_s <= 4'hF;
      tick <= '0;
      row <= 2'd0;
      hits <= 2'd0;
      code <= KEY_NONE;
    end else begin
      sync1 <= col_n;
      col_s <= sync1;
      tick <= slot_end ? '0 : tick + 1'b1;
      if (slot_end) begin
        row <= row + 1'b1;
        hits <= scan_valid ? 2'd0 : hits_nx;
        code <= scan_valid ? KEY_NONE : code_nx;
      end
    end
  end
  assign row_n = ~(4'b0001 << row);
  kp_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk(clk),
    .rst(rst),
    .scan_valid(scan_valid),
    .scan_code(scan_code),
    .keypad_pressed(keypad_pressed),
    .key(key),
    .key_strobe(key_strobe)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: table-driven and random keypad stimulus checked against a cycle-count based reference model
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int D = 3;
  localparam int NT = 16;
  localparam int NV = 46;
  typedef struct {
    logic rst;
    logic [15:0] mask;
    bit bnc;
    int cyc;
    bit chk;
    logic pressed;
    logic [4:0] key;
    int strobes;
    int lat;
    bit hold;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] col_n, row_n;
  logic keypad_pressed, key_strobe;
  logic [4:0] key;
  logic [15:0] eff_mask = '0;
  int vecs = 0, fails = 0;
  int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  vec_t tbl[NV];
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk),
    .rst(rst),
    .col_n(col_n),
    .row_n(row_n),
    .keypad_pressed(keypad_pressed),
    .key(key),
    .key_strobe(key_strobe)
  );
  always #5 clk = ~clk;
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && eff_mask[r*4+c]) col_n[c] = 1'b0;
  end
  int m_c, m_hits, m_run, m_r;
  logic [4:0] m_last, m_res, m_runc, m_key;
  logic [3:0] cn1, cn2;
  bit m_pressed, m_strobe;
  always @(posedge clk) begin
    if (rst) begin
      m_c = 0; m_hits = 0; m_run = 0; m_last = 31; m_runc = 31;
      cn1 = 4'hF; cn2 = 4'hF; m_pressed = 0; m_key = 31; m_strobe = 0;
    end else begin
      m_c++;
      m_strobe = 0;
      if (m_c % SD == 0) begin
        m_r = ((m_c - 1) / SD) % 4;
        for (int c = 0; c < 4; c++)
          if (!cn2[c]) begin
            m_hits++;
            m_last = 5'(kmap[m_r*4+c]);
          end
        if (m_r == 3) begin
          m_res = m_hits == 1 ? m_last : 5'd31;
          m_hits = 0;
          if (m_res == m_runc) m_run++;
          else begin
            m_runc = m_res;
            m_run = 1;
          end
          if (m_run == D) begin
            if (m_res != 5'd31) begin
              if (!m_pressed || m_res != m_key) begin
                m_key = m_res; m_pressed = 1; m_strobe = 1;
              end
            end else m_pressed = 0;
          end
        end
      end
      cn2 = cn1;
      cn1 = col_n;
    end
  end
  function automatic vec_t mk(logic r, logic [15:0] m, bit b, int n, bit ck, logic p, logic [4:0] k, int s, int l, bit h);
    vec_t v;
    v.rst = r; v.mask = m; v.bnc = b; v.cyc = n; v.chk = ck; v.pressed = p;
    v.key = k; v.strobes = s; v.lat = l; v.hold = h;
    return v;
  endfunction
  initial begin
    int strobes, lat, lows;
    logic [3:0] exp_row;
    tbl[0]  = mk(1, 16'h0000, 0, 2,   1, 0, 31, 0, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 0, 200, 1, 0, 31, 0, 0, 0);
    tbl[2]  = mk(0, 16'h8000, 0, 100, 1, 1, 13, 1, 66, 0);
    tbl[3]  = mk(0, 16'h0000, 0, 80,  1, 0, 13, 0, 66, 0);
    tbl[4]  = mk(0, 16'h0100, 1, 60,  0, 0, 0, -1, 0, 0);
    tbl[5]  = mk(0, 16'h0100, 0, 80,  1, 1, 7, -1, 66, 0);
    tbl[6]  = mk(0, 16'h0000, 0, 80,  1, 0, 7, 0, 66, 0);
    tbl[7]  = mk(0, 16'h0018, 0, 100, 1, 0, 7, 0, 0, 0);
    tbl[8]  = mk(0, 16'h0000, 0, 40,  1, 0, 7, 0, 0, 0);
    tbl[9]  = mk(0, 16'h0008, 0, 100, 1, 1, 10, 1, 66, 0);
    tbl[10] = mk(0, 16'h4000, 0, 100, 1, 1, 15, 1, 0, 1);
    tbl[11] = mk(0, 16'h0000, 0, 80,  1, 0, 15, 0, 66, 0);
    tbl[12] = mk(0, 16'h1000, 0, 100, 1, 1, 14, 1, 66, 0);
    tbl[13] = mk(1, 16'h1000, 0, 1,   1, 0, 31, 0, 0, 0);
    tbl[14] = mk(0, 16'h1000, 0, 100, 1, 1, 14, 1, 66, 0);
    tbl[15] = mk(0, 16'h0000, 0, 80,  1, 0, 14, 0, 66, 0);
    for (int i = NT; i < NV; i++) begin
      int ch;
      logic [15:0] m;
      ch = int'($urandom_range(0, 3));
      m = ch == 0 ? 16'h0 : 16'h1 << $urandom_range(0, 15);
      if (ch == 3) m = m | (16'h1 << $urandom_range(0, 15));
      tbl[i] = mk(0, m, $urandom_range(0, 4) == 0, int'($urandom_range(5, 120)), 0, 0, 0, -1, 0, 0);
    end
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst;
      strobes = 0; lat = -1; lows = 0;
      for (int k = 0; k < tbl[i].cyc; k++) begin
        eff_mask = (tbl[i].bnc && ((k / 10) % 2 == 1)) ? 16'h0 : tbl[i].mask;
        @(posedge clk);
        @(negedge clk);
        exp_row = ~(4'b0001 << ((m_c / SD) % 4));
        vecs++;
        if (row_n !== exp_row || keypad_pressed !== m_pressed || key !== m_key || key_strobe !== m_strobe) begin
          fails++;
          $display("FAIL cycle phase %0d k %0d: row_n=%b pressed=%b key=%0d strobe=%b, model row_n=%b pressed=%b key=%0d strobe=%b",
                   i, k, row_n, keypad_pressed, key, key_strobe, exp_row, m_pressed, m_key, m_strobe);
        end
        if (key_strobe) strobes++;
        if (!keypad_pressed) lows++;
        if (lat < 0 && keypad_pressed === tbl[i].pressed) lat = k + 1;
      end
      if (tbl[i].chk) begin
        vecs++;
        if (keypad_pressed !== tbl[i].pressed || key !== tbl[i].key) begin
          fails++;
          $display("FAIL end phase %0d: pressed=%b key=%0d, want pressed=%b key=%0d", i, keypad_pressed, key, tbl[i].pressed, tbl[i].key);
        end
      end
      if (tbl[i].rst) begin
        vecs++;
        if (row_n !== 4'b1110 || key_strobe !== 1'b0) begin
          fails++;
          $display("FAIL reset phase %0d: row_n=%b strobe=%b, want 1110 0", i, row_n, key_strobe);
        end
      end
      if (tbl[i].strobes >= 0) begin
        vecs++;
        if (strobes != tbl[i].strobes) begin
          fails++;
          $display("FAIL strobes phase %0d: got %0d, want %0d", i, strobes, tbl[i].strobes);
        end
      end
      if (tbl[i].lat > 0) begin
        vecs++;
        if (lat < 1 || lat > tbl[i].lat) begin
          fails++;
          $display("FAIL latency phase %0d: got %0d cycles, want 1..%0d", i, lat, tbl[i].lat);
        end
      end
      if (tbl[i].hold) begin
        vecs++;
        if (lows != 0) begin
          fails++;
          $display("FAIL hold phase %0d: pressed low %0d cycles, want 0", i, lows);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
